mul3_seq: RTL and testbench

- Parametrised, multi-cycle successor to the combinational three-operand multiplier.
- Computes P1 = a*b, then P2 = P1*c, using a shared-style shift-add datapath, one multiplier bit per clock.
- Wrapped in valid/ready handshakes so it can sit between a producer and a consumer in the datapath.
- Results are full width; no truncation of P2.

---
 rtl/mul3_seq_pkg.sv | 18 +
 rtl/mul3_seq_if.sv | 27 ++
 rtl/mul3_seq_mul_shift_add.sv | 77 +++++++
 rtl/mul3_seq.sv | 101 ++++++++++
 tb/tb_mul3_seq.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/mul3_seq_pkg.sv
// Shared types and helpers for the sequential three-operand multiplier.
package mul3_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL1,
    MUL2,
    DONE
  } state_e;

  // Counter width wide enough to index the longer of the two multiplier operands.
  function automatic int cnt_width(input int wb, input int wc);
    int m;
    m = (wb > wc) ? wb : wc;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/mul3_seq_if.sv
// Operand/result handshake bundle between a producer, mul3_seq and a consumer.
interface mul3_seq_if #(
  parameter int WA = 4,
  parameter int WB = 4,
  parameter int WC = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WA-1:0]         a;
  logic [WB-1:0]         b;
  logic [WC-1:0]         c;
  logic                  out_valid;
  logic                  out_ready;
  logic [WA+WB-1:0]      P1;
  logic [WA+WB+WC-1:0]   P2;
  logic                  busy;

  modport master (
    output in_valid, a, b, c, out_ready,
    input  in_ready, out_valid, P1, P2, busy
  );

  modport slave (
    input  in_valid, a, b, c, out_ready,
    output in_ready, out_valid, P1, P2, busy
  );
endinterface

// File: rtl/mul3_seq_mul_shift_add.sv
// One-bit-per-clock shift-add multiplier: start loads operands, done marks the
// cycle whose product output is the final result.
module mul_shift_add
  import mul3_pkg::*;
#(
  parameter int WM = 4,
  parameter int WN = 4,
  parameter int CW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WM-1:0]    mcand,
  input  logic [WN-1:0]    mplier,
  output logic             done,
  output logic [WM+WN-1:0] product
);
  localparam int WP = WM + WN;
  localparam logic [CW-1:0] LAST = CW'(WN - 1);

  logic            run_q, run_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WM-1:0]   mcand_q, mcand_d;
  logic [WN-1:0]   mplier_q, mplier_d;
  logic [WP-1:0]   acc_q, acc_d;
  logic [WP-1:0]   addend;

  // product is acc plus this cycle's partial term, so the last step is visible
  // combinationally and the parent can latch it on the same edge it finishes.
  always_comb begin
    addend  = mplier_q[0] ? ({{WN{1'b0}}, mcand_q} << cnt_q) : '0;
    product = acc_q + addend;
    done    = run_q && (cnt_q == LAST);
  end

  // NOTE: every always_comb output is given a default first so no latch is inferred.
  always_comb begin
    run_d    = run_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start) begin
      run_d    = 1'b1;
      cnt_d    = '0;
      mcand_d  = mcand;
      mplier_d = mplier;
      acc_d    = '0;
    end else if (run_q) begin
      acc_d    = product;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (done) begin
        run_d = 1'b0;
        cnt_d = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/mul3_seq.sv
// Sequential a*b*c multiplier with valid/ready handshakes: stage 1 forms P1=a*b,
// stage 2 forms P2=P1*c, one multiplier bit per clock each.
module mul3_seq
  import mul3_pkg::*;
#(
  parameter int WA = 4,
  parameter int WB = 4,
  parameter int WC = 8
) (
  input logic       clk,
  input logic       rst,
  mul3_seq_if.slave bus
);
  localparam int CW = cnt_width(WB, WC);
  localparam int W1 = WA + WB;
  localparam int W2 = WA + WB + WC;

  state_e          state_q, state_d;
  logic [WC-1:0]   c_q, c_d;
  logic [W1-1:0]   p1_q, p1_d;
  logic [W2-1:0]   p2_q, p2_d;
  logic            in_ready_q, out_valid_q, busy_q;

  logic            start1, start2, s1_done, s2_done;
  logic [W1-1:0]   s1_product;
  logic [W2-1:0]   s2_product;

  assign start1 = (state_q == IDLE) && bus.in_valid;
  assign start2 = s1_done;

  mul_shift_add #(.WM(WA), .WN(WB), .CW(CW)) u_stage1 (
    .clk     (clk),
    .rst     (rst),
    .start   (start1),
    .mcand   (bus.a),
    .mplier  (bus.b),
    .done    (s1_done),
    .product (s1_product)
  );

  mul_shift_add #(.WM(W1), .WN(WC), .CW(CW)) u_stage2 (
    .clk     (clk),
    .rst     (rst),
    .start   (start2),
    .mcand   (s1_product),
    .mplier  (c_q),
    .done    (s2_done),
    .product (s2_product)
  );

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    unique case (state_q)
      IDLE: if (bus.in_valid) begin
        c_d     = bus.c;
        state_d = MUL1;
      end
      MUL1: if (s1_done) begin
        p1_d    = s1_product;
        state_d = MUL2;
      end
      MUL2: if (s2_done) begin
        p2_d    = s2_product;
        state_d = DONE;
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      c_q         <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d == MUL1) || (state_d == MUL2);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.P1        = p1_q;
  assign bus.P2        = p2_q;

endmodule

// File: tb/tb_mul3_seq.sv
// Directed bench for mul3_seq: vector table, backpressure, mid-op reset and a
// wider parameter variant.
module tb_mul3_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul3_seq_if #(.WA(4), .WB(4), .WC(8))  bus0 ();
  mul3_seq_if #(.WA(8), .WB(8), .WC(16)) bus1 ();

  mul3_seq #(.WA(4), .WB(4), .WC(8))  dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mul3_seq #(.WA(8), .WB(8), .WC(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  b;
    logic [7:0]  c;
    logic [7:0]  p1;
    logic [15:0] p2;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Call at a negedge with the DUT in IDLE; returns at the negedge after the accept edge.
  task automatic accept0(input logic [3:0] a, input logic [3:0] b, input logic [7:0] c);
    bus0.in_valid = 1'b1;
    bus0.a = a;
    bus0.b = b;
    bus0.c = c;
    @(posedge clk);
    @(negedge clk);
    bus0.in_valid = 1'b0;
  endtask

  task automatic wait_done0(output int lat, output bit saw_ready);
    lat = 0;
    saw_ready = 1'b0;
    while (!bus0.out_valid && lat < 60) begin
      if (bus0.in_ready) saw_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release0(input string name);
    bus0.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.out_ready = 1'b0;
    check({name, "_ov_drop"}, bus0.out_valid, 0);
    check({name, "_in_ready"}, bus0.in_ready, 1);
  endtask

  task automatic run_vec0(input vec_t v, input string name);
    int lat;
    bit saw_ready;
    @(negedge clk);
    accept0(v.a, v.b, v.c);
    check({name, "_busy"}, bus0.busy, 1);
    wait_done0(lat, saw_ready);
    check({name, "_latency"}, lat, 12);
    check({name, "_in_ready_low"}, saw_ready, 0);
    check({name, "_P1"}, bus0.P1, v.p1);
    check({name, "_P2"}, bus0.P2, v.p2);
    check({name, "_busy_done"}, bus0.busy, 0);
    release0(name);
  endtask

  initial begin
    int lat;
    bit saw_ready;
    int seen_ov;

    vecs[0] = '{a: 4'd3,  b: 4'd4,  c: 8'd4,   p1: 8'd12,  p2: 16'd48};
    vecs[1] = '{a: 4'd15, b: 4'd15, c: 8'd255, p1: 8'd225, p2: 16'd57375};
    vecs[2] = '{a: 4'd0,  b: 4'd9,  c: 8'd200, p1: 8'd0,   p2: 16'd0};
    for (int i = 1; i <= 15; i++) begin
      vecs[2 + i].a  = 4'(i - 1);
      vecs[2 + i].b  = 4'(i);
      vecs[2 + i].c  = 8'(i);
      vecs[2 + i].p1 = 8'((i - 1) * i);
      vecs[2 + i].p2 = 16'((i - 1) * i * i);
    end

    rst = 1'b1;
    bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.c = '0; bus0.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.c = '0; bus1.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", bus0.in_ready, 1);
    check("rst_out_valid", bus0.out_valid, 0);
    check("rst_busy", bus0.busy, 0);
    check("rst_P1", bus0.P1, 0);
    check("rst_P2", bus0.P2, 0);

    // Plans 1-3: table of directed vectors plus the a=i-1, b=i, c=i sweep.
    for (int i = 0; i < 18; i++) run_vec0(vecs[i], $sformatf("vec%0d", i));

    // Plan 4: backpressure in DONE with in_valid toggling on new operands.
    @(negedge clk);
    accept0(4'd5, 4'd6, 8'd7);
    wait_done0(lat, saw_ready);
    check("bp_latency", lat, 12);
    for (int k = 0; k < 5; k++) begin
      bus0.in_valid = (k % 2 == 0);
      bus0.a = 4'd1; bus0.b = 4'd1; bus0.c = 8'd1;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp_ov_%0d", k), bus0.out_valid, 1);
      check($sformatf("bp_P1_%0d", k), bus0.P1, 30);
      check($sformatf("bp_P2_%0d", k), bus0.P2, 210);
      check($sformatf("bp_in_ready_%0d", k), bus0.in_ready, 0);
    end
    // Simultaneous in_valid and out_ready: only the result handshake completes.
    bus0.in_valid = 1'b1;
    bus0.a = 4'd2; bus0.b = 4'd3; bus0.c = 8'd4;
    bus0.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.out_ready = 1'b0;
    check("sim_ov_drop", bus0.out_valid, 0);
    check("sim_in_ready", bus0.in_ready, 1);
    check("sim_not_busy", bus0.busy, 0);
    @(posedge clk);
    @(negedge clk);
    bus0.in_valid = 1'b0;
    wait_done0(lat, saw_ready);
    check("sim_latency", lat, 12);
    check("sim_P1", bus0.P1, 6);
    check("sim_P2", bus0.P2, 24);
    release0("sim");

    // Plan 5: reset at the fifth edge after accept aborts the operation.
    @(negedge clk);
    accept0(4'd9, 4'd9, 8'd9);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mrst_in_ready", bus0.in_ready, 1);
    check("mrst_out_valid", bus0.out_valid, 0);
    check("mrst_busy", bus0.busy, 0);
    check("mrst_P1", bus0.P1, 0);
    check("mrst_P2", bus0.P2, 0);
    seen_ov = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus0.out_valid) seen_ov++;
    end
    check("mrst_no_result", seen_ov, 0);
    run_vec0('{a: 4'd7, b: 4'd8, c: 8'd9, p1: 8'd56, p2: 16'd504}, "post_rst");

    // Plan 6: wider parameter variant.
    @(negedge clk);
    bus1.in_valid = 1'b1;
    bus1.a = 8'd255; bus1.b = 8'd255; bus1.c = 16'd65535;
    @(posedge clk);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    lat = 0;
    while (!bus1.out_valid && lat < 80) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("wide_latency", lat, 24);
    check("wide_P1", bus1.P1, 64'd65025);
    check("wide_P2", bus1.P2, 64'd4261413375);
    bus1.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.out_ready = 1'b0;
    check("wide_ov_drop", bus1.out_valid, 0);
    check("wide_in_ready", bus1.in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
